// File: rtl/vga_timing_generator.sv
// vga_timing_generator: parametrised raster timing with pixel divider, x/y counters, registered syncs and strobes
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_ON = SYNC_POL != 0;

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1 ||
      (2 ** CW) <= H_TOTAL - 1 || (2 ** CW) <= V_TOTAL - 1) begin : g_illegal
    $error("vga_timing_generator: illegal timing parameters");
  end

  logic [DW-1:0] div;
  logic          adv;
  logic          x_wrap;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;

  always_comb begin
    adv    = en && div == DIV_MAX;
    x_wrap = x == H_MAX;
    nx     = x_wrap ? '0 : x + CW'(1);
    ny     = x_wrap ? (y == V_MAX ? '0 : y + CW'(1)) : y;
  end

  // decodes are taken from the next x/y so they land in the same cycle as the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      x           <= H_MAX;
      y           <= V_MAX;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      active      <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= adv;
      line_start  <= adv && nx == '0;
      frame_start <= adv && nx == '0 && ny == '0;
      if (en) div <= div == DIV_MAX ? '0 : div + DW'(1);
      if (adv) begin
        x      <= nx;
        y      <= ny;
        hsync  <= (nx >= HS_BEG && nx < HS_END) ? SYNC_ON : ~SYNC_ON;
        vsync  <= (ny >= VS_BEG && ny < VS_END) ? SYNC_ON : ~SYNC_ON;
        active <= nx < H_ACT && ny < V_ACT;
      end
    end
  end
endmodule
